// File: rtl/product_bcd_display_pkg.sv
// Shared types and constants for the product-to-7-segment display path.
package product_bcd_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned CONV_BITS  = 8;
  localparam int unsigned CNT_W      = $clog2(CONV_BITS);
  localparam int unsigned BCD_W      = 12;
  localparam int unsigned SEG_W      = 7;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int i = 0; i < 3; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/product_bcd_display_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder with blanking.
module bcd_to_seg7
  import product_bcd_display_pkg::*;
(
  input  logic [3:0]       digit,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  // Codes above 9 and blanked digits turn every segment off
  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/product_bcd_display.sv
// Captures an 8-bit product, converts it to BCD one bit per clock and
// drives a multiplexed 4-digit common-anode 7-segment display.
module product_bcd_display
  import product_bcd_display_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 16,
  parameter bit          LEAD_BLANK   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [7:0]            p,
  output logic                  busy,
  output logic                  done,
  output logic [BCD_W-1:0]      bcd,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg
);

  state_t                  state;
  logic [7:0]              sreg;
  logic [BCD_W-1:0]        acc;
  logic [CNT_W-1:0]        bit_cnt;
  logic [REFRESH_BITS-1:0] refresh;

  logic [BCD_W+7:0]        shift_c;
  logic [1:0]              idx_c;
  logic [3:0]              digit_c;
  logic                    blank_c;
  logic [NUM_DIGITS-1:0]   an_c;
  logic [SEG_W-1:0]        seg_dec_c;

  // One double-dabble step: correct nibbles, then shift {acc, sreg} left
  assign shift_c = {dabble_adjust(acc), sreg} << 1;

  // Conversion FSM and datapath; bcd only changes when a conversion completes
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      sreg    <= '0;
      acc     <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            sreg    <= p;
            acc     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          acc     <= shift_c[BCD_W+7:8];
          sreg    <= shift_c[7:0];
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(CONV_BITS - 1)) begin
            bcd   <= shift_c[BCD_W+7:8];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running refresh counter; top two bits pick the active digit
  always_ff @(posedge clk) begin
    if (rst) refresh <= '0;
    else     refresh <= refresh + REFRESH_BITS'(1);
  end

  assign idx_c = refresh[REFRESH_BITS-1 -: 2];

  // Digit mux with leading-zero blanking; slot 3 is always dark
  always_comb begin
    digit_c = 4'd0;
    blank_c = 1'b1;
    an_c    = ~(NUM_DIGITS'(1) << idx_c);
    case (idx_c)
      2'd0: begin
        digit_c = bcd[3:0];
        blank_c = 1'b0;
      end
      2'd1: begin
        digit_c = bcd[7:4];
        blank_c = LEAD_BLANK && (bcd[11:4] == 8'd0);
      end
      2'd2: begin
        digit_c = bcd[11:8];
        blank_c = LEAD_BLANK && (bcd[11:8] == 4'd0);
      end
      default: begin
        digit_c = 4'd0;
        blank_c = 1'b1;
      end
    endcase
  end

  bcd_to_seg7 u_dec (
    .digit (digit_c),
    .blank (blank_c),
    .seg_c (seg_dec_c)
  );

  // Register the pins so anode and segment changes land on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1110;
      seg <= SEG_0;
    end else begin
      an  <= an_c;
      seg <= seg_dec_c;
    end
  end

endmodule

// File: tb/tb_product_bcd_display.sv
// Bench for product_bcd_display: vector table, scoreboard and corner sequences.
module tb_product_bcd_display;

  logic        clk, rst, load;
  logic [7:0]  p;
  logic        busy, done, busy_nb, done_nb;
  logic [11:0] bcd, bcd_nb;
  logic [3:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  logic [11:0] last_bcd = 12'h000;
  logic [11:0] sb_q[$];

  typedef struct packed {
    logic [7:0]       p;
    logic [11:0]      bcd;
    logic [3:0][6:0]  seg_lb;   // [3]=blank slot, [2]=hundreds, [1]=tens, [0]=ones
    logic [3:0][6:0]  seg_nb;
  } vec_t;

  vec_t vecs[9];

  product_bcd_display #(.REFRESH_BITS(4), .LEAD_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .p(p),
    .busy(busy), .done(done), .bcd(bcd), .an(an), .seg(seg)
  );

  product_bcd_display #(.REFRESH_BITS(4), .LEAD_BLANK(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .p(p),
    .busy(busy_nb), .done(done_nb), .bcd(bcd_nb), .an(an_nb), .seg(seg_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive a one-cycle load strobe; optionally push the expected result
  task automatic start_load(input logic [7:0] v, input logic [11:0] exp, input bit push);
    load = 1'b1;
    p    = v;
    tick();
    load = 1'b0;
    t0   = cyc;
    if (push) sb_q.push_back(exp);
  endtask

  // Wait (bounded) for done; checks busy, bcd hold, latency and the result
  task automatic wait_done();
    int n;
    logic [11:0] exp;
    n = cyc - t0 + 1;
    while (!done && n < 20) begin
      if (n <= 8) check("busy_during_conv", busy, 1'b1);
      check("bcd_hold", bcd, last_bcd);
      tick();
      n = cyc - t0 + 1;
    end
    if (!done) begin
      check("done_timeout", done, 1'b1);
    end else begin
      check("done_latency", n, 9);
      check("busy_at_done", busy, 1'b0);
      check("done_nb", done_nb, 1'b1);
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp = sb_q.pop_front();
        check("bcd_result", bcd, exp);
        check("bcd_result_nb", bcd_nb, exp);
        last_bcd = exp;
      end
    end
  endtask

  // Observe a full refresh cycle on both displays
  task automatic sweep(input logic [3:0][6:0] exp_lb, input logic [3:0][6:0] exp_nb);
    int idx, idx_nb;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("no_extra_done", done, 1'b0);
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      case (an_nb)
        4'b1110: idx_nb = 0;
        4'b1101: idx_nb = 1;
        4'b1011: idx_nb = 2;
        4'b0111: idx_nb = 3;
        default: idx_nb = -1;
      endcase
      if (idx < 0) check("an_onehot", an, 4'b1110);
      else         check("seg_lead_blank", seg, exp_lb[idx]);
      if (idx_nb < 0) check("an_onehot_nb", an_nb, 4'b1110);
      else            check("seg_no_blank", seg_nb, exp_nb[idx_nb]);
    end
  endtask

  // Confirm no done pulse shows up for a number of cycles
  task automatic no_done(input int ncyc);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (done) seen++;
    end
    check("spurious_done", seen, 0);
  endtask

  initial begin
    vecs[0] = '{8'd225, 12'h225, {7'h7F, 7'h24, 7'h24, 7'h12}, {7'h7F, 7'h24, 7'h24, 7'h12}};
    vecs[1] = '{8'd168, 12'h168, {7'h7F, 7'h79, 7'h02, 7'h00}, {7'h7F, 7'h79, 7'h02, 7'h00}};
    vecs[2] = '{8'd77,  12'h077, {7'h7F, 7'h7F, 7'h78, 7'h78}, {7'h7F, 7'h40, 7'h78, 7'h78}};
    vecs[3] = '{8'd7,   12'h007, {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h40, 7'h40, 7'h78}};
    vecs[4] = '{8'd0,   12'h000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{8'd255, 12'h255, {7'h7F, 7'h24, 7'h12, 7'h12}, {7'h7F, 7'h24, 7'h12, 7'h12}};
    vecs[6] = '{8'd100, 12'h100, {7'h7F, 7'h79, 7'h40, 7'h40}, {7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[7] = '{8'd9,   12'h009, {7'h7F, 7'h7F, 7'h7F, 7'h10}, {7'h7F, 7'h40, 7'h40, 7'h10}};
    vecs[8] = '{8'd50,  12'h050, {7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h7F, 7'h40, 7'h12, 7'h40}};

    rst  = 1'b1;
    load = 1'b0;
    p    = 8'd0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bcd", bcd, 12'h000);
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'h40);
    rst = 1'b0;
    sweep(vecs[4].seg_lb, vecs[4].seg_nb);

    // Table of single conversions, each followed by a display sweep
    for (int i = 0; i < 9; i++) begin
      start_load(vecs[i].p, vecs[i].bcd, 1'b1);
      wait_done();
      sweep(vecs[i].seg_lb, vecs[i].seg_nb);
    end

    // Back-to-back: a load in the done cycle is accepted
    start_load(8'd168, 12'h168, 1'b1);
    wait_done();
    start_load(8'd77, 12'h077, 1'b1);
    wait_done();
    sweep(vecs[2].seg_lb, vecs[2].seg_nb);

    // Load while busy is ignored and p changes mid-conversion have no effect
    start_load(8'd200, 12'h200, 1'b1);
    tick();
    tick();
    load = 1'b1;
    p    = 8'd5;
    tick();
    load = 1'b0;
    p    = 8'd99;
    wait_done();
    no_done(12);
    check("sb_empty", sb_q.size(), 0);

    // Reset during conversion aborts it
    start_load(8'd255, 12'h255, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_bcd", bcd, 12'h000);
    check("abort_bcd_nb", bcd_nb, 12'h000);
    last_bcd = 12'h000;
    no_done(12);
    start_load(8'd0, 12'h000, 1'b1);
    wait_done();
    sweep(vecs[4].seg_lb, vecs[4].seg_nb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
